// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency-meter counter slice.
// No ports; imported by bcd_digit and bcd_gated_counter.
package freq_meter_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        LATCH
    } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the running count.
// Ports:
//   clk_50M  system clock
//   rst_n    asynchronous active-low reset
//   clr      synchronous zero, wins over inc
//   inc      global increment strobe for this cycle
//   cin      carry from the lower decade (tie to 1 for the units digit)
//   q        current decade value, always 0..9
//   cout     carry to the next decade: cin while this decade sits at 9
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             cin,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    // Combinational so a full ripple resolves within one cycle.
    assign cout = cin & (q == BCD_MAX);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && cin) begin
            q <= (q == BCD_MAX) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_gated_counter.sv
// Gated decade counter for the frequency meter.
// Counts rising edges of ext_signal while the gate counter_en is high and,
// when the gate closes, latches the count into result with a one-cycle
// result_valid pulse. All asynchronous inputs are synchronised to clk_50M.
//
// Build option: BCD_CNT_SATURATE_EN
//   defined     - on overflow the count holds at all 9s, further edges ignored
//   not defined - on overflow the count wraps to 0 and keeps counting
//   In both cases the sticky overflow flag is reported through over.
//
// Ports:
//   clk_50M       system clock
//   rst_n         asynchronous active-low reset
//   ext_signal    measured signal (async)
//   counter_en    gate, count while high (async)
//   clear         zero count/result/over request (async)
//   result        latched BCD count, digit k at [4k+3:4k]
//   over          overflow flag belonging to result
//   result_valid  one-cycle pulse when result/over update
//   busy          high while the FSM is in COUNT or LATCH
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the gate; count is zeroed when the gate is seen high
// COUNT | gate open, each synchronised rising edge adds one
// LATCH | gate closed, copy count/ovf into result/over, pulse result_valid
module bcd_gated_counter
    import freq_meter_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_50M,
    input  logic                        rst_n,
    input  logic                        ext_signal,
    input  logic                        counter_en,
    input  logic                        clear,
    output logic [BCD_W*NUM_DIGITS-1:0] result,
    output logic                        over,
    output logic                        result_valid,
    output logic                        busy
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_gated_counter: NUM_DIGITS out of range 1..16");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("bcd_gated_counter: SYNC_STAGES out of range 2..4");
    end

    logic [SYNC_STAGES-1:0] ext_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   ext_prev;
    logic                   ext_s;
    logic                   en_s;
    logic                   clr_s;
    logic                   edge_p;

    state_t                        state;
    logic                          ovf;
    logic [BCD_W*NUM_DIGITS-1:0]   count;
    logic [NUM_DIGITS:0]           carry;
    logic                          all_nines;
    logic                          count_step;
    logic                          digit_clr;
    logic                          digit_inc;

    // ---------------------------------------------------------------
    // Synchronisers and edge detector
    // ---------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync <= '0;
            en_sync  <= '0;
            clr_sync <= '0;
            ext_prev <= 1'b0;
        end else begin
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_signal};
            en_sync  <= {en_sync[SYNC_STAGES-2:0], counter_en};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], clear};
            ext_prev <= ext_s;
        end
    end

    assign ext_s  = ext_sync[SYNC_STAGES-1];
    assign en_s   = en_sync[SYNC_STAGES-1];
    assign clr_s  = clr_sync[SYNC_STAGES-1];
    assign edge_p = ext_s & ~ext_prev;

    // ---------------------------------------------------------------
    // Running count: ripple-carry chain of decades
    // ---------------------------------------------------------------
    // carry[NUM_DIGITS] is high exactly when every decade holds 9.
    assign carry[0]   = 1'b1;
    assign all_nines  = carry[NUM_DIGITS];

    // The edge in the cycle en_s is first seen low is deliberately dropped.
    assign count_step = (state == COUNT) & en_s & edge_p;
    assign digit_clr  = clr_s | ((state == IDLE) & en_s);

`ifdef BCD_CNT_SATURATE_EN
    assign digit_inc = count_step & ~all_nines;
`else
    assign digit_inc = count_step;
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk_50M (clk_50M),
            .rst_n   (rst_n),
            .clr     (digit_clr),
            .inc     (digit_inc),
            .cin     (carry[k]),
            .q       (count[BCD_W*k +: BCD_W]),
            .cout    (carry[k+1])
        );
    end

    // ---------------------------------------------------------------
    // Control FSM, overflow flag and result register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ovf          <= 1'b0;
            result       <= '0;
            over         <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else if (clr_s) begin
            state        <= IDLE;
            ovf          <= 1'b0;
            result       <= '0;
            over         <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_s) begin
                        state <= COUNT;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (!en_s) begin
                        state <= LATCH;
                    end else if (edge_p && all_nines) begin
                        ovf <= 1'b1;
                    end
                end
                LATCH: begin
                    result       <= count;
                    over         <= ovf;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_gated_counter.sv
module tb_bcd_gated_counter;

    logic        clk_50M = 1'b0;
    logic        rst_n;
    logic        ext_signal;
    logic        counter_en;
    logic        clear;

    logic [31:0] result_a;
    logic        over_a, rv_a, busy_a;
    logic [7:0]  result_b;
    logic        over_b, rv_b, busy_b;

    int checks   = 0;
    int failures = 0;

    logic [32:0] cap_a[$];
    logic [8:0]  cap_b[$];

    always #10 clk_50M = ~clk_50M;

    bcd_gated_counter #(.NUM_DIGITS(8), .SYNC_STAGES(2)) dut_a (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .ext_signal   (ext_signal),
        .counter_en   (counter_en),
        .clear        (clear),
        .result       (result_a),
        .over         (over_a),
        .result_valid (rv_a),
        .busy         (busy_a)
    );

    bcd_gated_counter #(.NUM_DIGITS(2), .SYNC_STAGES(3)) dut_b (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .ext_signal   (ext_signal),
        .counter_en   (counter_en),
        .clear        (clear),
        .result       (result_b),
        .over         (over_b),
        .result_valid (rv_b),
        .busy         (busy_b)
    );

    // Every sampled-high result_valid cycle captures one {over,result} word,
    // so a pulse longer than one cycle shows up as an extra entry.
    always @(negedge clk_50M) begin
        if (rv_a) cap_a.push_back({over_a, result_a});
        if (rv_b) cap_b.push_back({over_b, result_b});
    end

    // Reference: decimal edge count -> {over, BCD digits} for nd decades.
    function automatic logic [63:0] exp_word(longint e, int nd);
        logic [63:0] r;
        longint      lim;
        longint      v;
        logic        ov;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ov = (e >= lim);
`ifdef BCD_CNT_SATURATE_EN
        v = ov ? lim - 1 : e;
`else
        v = e % lim;
`endif
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        r[4*nd] = ov;
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic pulses(int n, int hmin, int hmax, int lmin, int lmax);
        for (int i = 0; i < n; i++) begin
            ext_signal = 1'b1;
            tick($urandom_range(hmax, hmin));
            ext_signal = 1'b0;
            tick($urandom_range(lmax, lmin));
        end
    endtask

    task automatic check_gate(string tag, longint e);
        logic [63:0] got;
        check({tag, "_nvalid_a"}, 64'(cap_a.size()), 64'd1);
        got = 'x;
        if (cap_a.size() > 0) got = 64'(cap_a.pop_front());
        check({tag, "_a"}, got, exp_word(e, 8));
        check({tag, "_nvalid_b"}, 64'(cap_b.size()), 64'd1);
        got = 'x;
        if (cap_b.size() > 0) got = 64'(cap_b.pop_front());
        check({tag, "_b"}, got, exp_word(e, 2));
        cap_a.delete();
        cap_b.delete();
    endtask

    task automatic run_gate(string tag, int n, int hmin, int hmax, int lmin, int lmax);
        counter_en = 1'b1;
        tick(6);
        check({tag, "_busy_on"}, {62'd0, busy_a, busy_b}, 64'd3);
        pulses(n, hmin, hmax, lmin, lmax);
        tick(6);
        counter_en = 1'b0;
        tick(12);
        check({tag, "_busy_off"}, {62'd0, busy_a, busy_b}, 64'd0);
        check_gate(tag, n);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        ext_signal = 1'b0;
        counter_en = 1'b0;
        clear      = 1'b0;
        tick(3);
        check("reset_a", {30'd0, over_a, rv_a, busy_a, result_a}, 64'd0);
        check("reset_b", {54'd0, over_b, rv_b, busy_b, result_b}, 64'd0);
        rst_n = 1'b1;
        tick(4);

        // Gate of ~1000 cycles, ext period 10 -> 100 edges.
        run_gate("t1_period10", 100, 5, 5, 5, 5);

        // Carry ripple through three decades (999 -> 1000) plus one more.
        run_gate("t2_ripple", 1001, 2, 2, 3, 3);

        // Two-digit instance passes 99 within one gate.
        run_gate("t3_ovf105", 105, 2, 3, 3, 4);

        // Clear mid-gate: no result_valid, outputs zeroed.
        counter_en = 1'b1;
        tick(6);
        pulses(50, 2, 3, 3, 4);
        clear      = 1'b1;
        counter_en = 1'b0;
        tick(3);
        clear = 1'b0;
        tick(12);
        check("t4_clr_nvalid_a", 64'(cap_a.size()), 64'd0);
        check("t4_clr_nvalid_b", 64'(cap_b.size()), 64'd0);
        check("t4_clr_out_a", {31'd0, over_a, busy_a, result_a}, 64'd0);
        check("t4_clr_out_b", {55'd0, over_b, busy_b, result_b}, 64'd0);
        cap_a.delete();
        cap_b.delete();
        run_gate("t4_after_clr", 7, 2, 3, 3, 4);

        // Asynchronous reset in the middle of a gate, between clock edges.
        counter_en = 1'b1;
        tick(6);
        pulses(20, 2, 3, 3, 4);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_a", {30'd0, over_a, rv_a, busy_a, result_a}, 64'd0);
        check("t5_rst_b", {54'd0, over_b, rv_b, busy_b, result_b}, 64'd0);
        counter_en = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        cap_a.delete();
        cap_b.delete();
        n = $urandom_range(40, 5);
        run_gate("t5_after_rst", n, 2, 3, 3, 4);

        // Back-to-back gates separated by a single low cycle.
        counter_en = 1'b1;
        tick(6);
        pulses(3, 2, 3, 3, 4);
        tick(6);
        counter_en = 1'b0;
        tick(1);
        counter_en = 1'b1;
        tick(8);
        pulses(4, 2, 3, 3, 4);
        tick(6);
        counter_en = 1'b0;
        tick(14);
        check("t6_nvalid_a", 64'(cap_a.size()), 64'd2);
        check("t6_nvalid_b", 64'(cap_b.size()), 64'd2);
        if (cap_a.size() == 2) begin
            check("t6_first_a", 64'(cap_a[0]), exp_word(3, 8));
            check("t6_second_a", 64'(cap_a[1]), exp_word(4, 8));
        end
        if (cap_b.size() == 2) begin
            check("t6_first_b", 64'(cap_b[0]), exp_word(3, 2));
            check("t6_second_b", 64'(cap_b[1]), exp_word(4, 2));
        end
        cap_a.delete();
        cap_b.delete();

        // Randomised gates: edge count and edge spacing vary.
        for (int g = 0; g < 6; g++) begin
            n = $urandom_range(150, 0);
            run_gate($sformatf("rand%0d", g), n, 2, 4, 3, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
